// File: rtl/siso_shift_sequencer_nb.sv
// Feeds an N-bit SISO shift register from a valid/ready source, inserting
// drain shifts on direction change or flush and flagging real output words.
module siso_shift_sequencer_nb #(
    parameter int BUS_WIDTH  = 8,
    parameter int SISO_WIDTH = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 S_VALID,
    output logic                 S_READY,
    input  logic [BUS_WIDTH-1:0] S_DATA,
    input  logic                 S_DIR,
    input  logic                 FLUSH,
    input  logic                 HOLD,
    output logic [1:0]           SHIFT,
    output logic [BUS_WIDTH-1:0] SH_IN,
    output logic                 OUT_VALID,
    output logic                 BUSY
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_ST,
        DRAIN
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  cur_dir;
    logic                  cur_dir_nxt;
    logic [SISO_WIDTH-1:0] vbits;
    logic [SISO_WIDTH-1:0] vbits_nxt;
    logic                  flush_pend;
    logic                  drain_done;

    logic [BUS_WIDTH:0]    mem [FIFO_DEPTH];
    logic [PW:0]           wptr;
    logic [PW:0]           rptr;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  head_dir;
    logic [BUS_WIDTH-1:0]  head_data;
    logic                  exit_bit;
    logic                  in_valid;
    logic [1:0]            dir_shift;

    assign empty     = (wptr == rptr);
    assign full      = (wptr[PW-1:0] == rptr[PW-1:0]) && (wptr[PW] != rptr[PW]);
    assign S_READY   = !full;
    assign push      = S_VALID && !full;
    assign head_dir  = mem[rptr[PW-1:0]][BUS_WIDTH];
    assign head_data = mem[rptr[PW-1:0]][BUS_WIDTH-1:0];
    assign exit_bit  = cur_dir ? vbits[0] : vbits[SISO_WIDTH-1];
    assign dir_shift = cur_dir ? 2'b10 : 2'b01;
    assign BUSY      = (state != IDLE) || !empty || (|vbits);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wptr[PW-1:0]] <= {S_DIR, S_DATA};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            cur_dir    <= 1'b0;
            vbits      <= '0;
            flush_pend <= 1'b0;
        end else begin
            state   <= state_nxt;
            cur_dir <= cur_dir_nxt;
            vbits   <= vbits_nxt;
            if (FLUSH) begin
                flush_pend <= 1'b1;
            end else if (drain_done || (vbits == '0 && empty)) begin
                flush_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cur_dir_nxt = cur_dir;
        vbits_nxt   = vbits;
        pop         = 1'b0;
        drain_done  = 1'b0;
        in_valid    = 1'b0;
        SHIFT       = 2'b00;
        SH_IN       = '0;
        OUT_VALID   = 1'b0;
        if (!HOLD) begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        if (head_dir == cur_dir || vbits == '0) begin
                            cur_dir_nxt = head_dir;
                            state_nxt   = SHIFT_ST;
                        end else begin
                            state_nxt = DRAIN;
                        end
                    end else if (flush_pend && vbits != '0) begin
                        state_nxt = DRAIN;
                    end
                end
                SHIFT_ST: begin
                    if (empty) begin
                        state_nxt = IDLE;
                    end else if (head_dir == cur_dir) begin
                        pop       = 1'b1;
                        in_valid  = 1'b1;
                        SHIFT     = dir_shift;
                        SH_IN     = head_data;
                        OUT_VALID = exit_bit;
                    end else begin
                        state_nxt = (vbits != '0) ? DRAIN : IDLE;
                    end
                end
                DRAIN: begin
                    SHIFT     = dir_shift;
                    OUT_VALID = exit_bit;
                end
                default: state_nxt = IDLE;
            endcase
            // Occupancy mirror follows whatever shift is actually issued
            if (SHIFT != 2'b00) begin
                vbits_nxt = cur_dir ? {in_valid, vbits[SISO_WIDTH-1:1]}
                                    : {vbits[SISO_WIDTH-2:0], in_valid};
            end
            if (state == DRAIN && vbits_nxt == '0) begin
                drain_done = 1'b1;
                state_nxt  = IDLE;
            end
        end
    end

endmodule

// File: tb/tb_siso_shift_sequencer_nb.sv
// Directed bench: sequencer driving a behavioural SISO register model,
// with a log of every shift cycle compared to hand-derived tables.
module tb_siso_shift_sequencer_nb;

    logic       CLK;
    logic       RST;
    logic       S_VALID;
    logic       S_READY;
    logic [7:0] S_DATA;
    logic       S_DIR;
    logic       FLUSH;
    logic       HOLD;
    logic [1:0] SHIFT;
    logic [7:0] SH_IN;
    logic       OUT_VALID;
    logic       BUSY;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0] sh;
        logic [7:0] din;
        logic       ov;
        logic [7:0] out;
    } ent_t;

    ent_t       lq[$];
    logic [7:0] sr [4];
    logic [1:0] exp_sh  [32];
    logic [7:0] exp_din [32];
    logic       exp_ov  [32];
    logic [7:0] exp_out [32];

    siso_shift_sequencer_nb #(
        .BUS_WIDTH (8),
        .SISO_WIDTH(4),
        .FIFO_DEPTH(4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .S_VALID  (S_VALID),
        .S_READY  (S_READY),
        .S_DATA   (S_DATA),
        .S_DIR    (S_DIR),
        .FLUSH    (FLUSH),
        .HOLD     (HOLD),
        .SHIFT    (SHIFT),
        .SH_IN    (SH_IN),
        .OUT_VALID(OUT_VALID),
        .BUSY     (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        for (int i = 0; i < 4; i++) sr[i] = 8'hEE;
    end

    // Downstream shift register model
    always @(posedge CLK) begin
        if (SHIFT == 2'b01) begin
            for (int i = 3; i > 0; i--) sr[i] <= sr[i-1];
            sr[0] <= SH_IN;
        end else if (SHIFT == 2'b10) begin
            for (int i = 0; i < 3; i++) sr[i] <= sr[i+1];
            sr[3] <= SH_IN;
        end
    end

    always @(negedge CLK) begin
        if (SHIFT != 2'b00 || OUT_VALID) begin
            lq.push_back('{SHIFT, SH_IN, OUT_VALID,
                           (SHIFT == 2'b10) ? sr[0] : sr[3]});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ex(input int i, input logic [1:0] sh, input logic [7:0] d,
                      input logic ov, input logic [7:0] o);
        exp_sh[i]  = sh;
        exp_din[i] = d;
        exp_ov[i]  = ov;
        exp_out[i] = o;
    endtask

    task automatic check_log(input string tag, input int n);
        chk($sformatf("%s.len", tag), lq.size(), n);
        for (int i = 0; i < n && i < lq.size(); i++) begin
            chk($sformatf("%s[%0d].shift", tag, i), lq[i].sh, exp_sh[i]);
            chk($sformatf("%s[%0d].sh_in", tag, i), lq[i].din, exp_din[i]);
            chk($sformatf("%s[%0d].out_valid", tag, i), lq[i].ov, exp_ov[i]);
            if (exp_ov[i])
                chk($sformatf("%s[%0d].out", tag, i), lq[i].out, exp_out[i]);
        end
        lq.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] d, input logic dir);
        bit acc;
        acc     = 1'b0;
        S_VALID = 1'b1;
        S_DATA  = d;
        S_DIR   = dir;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = S_READY;
            @(posedge CLK);
            #1;
        end
        chk("push_accept", acc, 1'b1);
        S_VALID = 1'b0;
    endtask

    task automatic pulse_flush();
        FLUSH = 1'b1;
        tick(1);
        FLUSH = 1'b0;
    endtask

    initial begin
        RST = 1'b1; S_VALID = 1'b0; S_DATA = '0; S_DIR = 1'b0;
        FLUSH = 1'b0; HOLD = 1'b0;
        tick(2);
        chk("rst_shift", SHIFT, 2'b00);
        chk("rst_sh_in", SH_IN, 8'h00);
        chk("rst_out_valid", OUT_VALID, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_s_ready", S_READY, 1'b1);
        RST = 1'b0;
        tick(1);

        // Reset with three words buffered
        HOLD = 1'b1;
        push(8'hA1, 1'b0);
        push(8'hA2, 1'b0);
        push(8'hA3, 1'b0);
        @(negedge CLK);
        chk("pre_rst_busy", BUSY, 1'b1);
        RST = 1'b1;
        #1;
        chk("in_rst_shift", SHIFT, 2'b00);
        chk("in_rst_out_valid", OUT_VALID, 1'b0);
        chk("in_rst_busy", BUSY, 1'b0);
        chk("in_rst_s_ready", S_READY, 1'b1);
        HOLD = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_shift", SHIFT, 2'b00);
        chk("post_rst_out_valid", OUT_VALID, 1'b0);
        chk("post_rst_busy", BUSY, 1'b0);
        chk("post_rst_s_ready", S_READY, 1'b1);
        tick(4);
        chk("post_rst_idle_busy", BUSY, 1'b0);
        check_log("post_rst_log", 0);

        // Left stream of five words
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        push(8'h44, 1'b0);
        push(8'h55, 1'b0);
        tick(10);
        ex(0, 2'b01, 8'h11, 1'b0, 8'h00);
        ex(1, 2'b01, 8'h22, 1'b0, 8'h00);
        ex(2, 2'b01, 8'h33, 1'b0, 8'h00);
        ex(3, 2'b01, 8'h44, 1'b0, 8'h00);
        ex(4, 2'b01, 8'h55, 1'b1, 8'h11);
        check_log("left", 5);
        pulse_flush();
        tick(8);
        ex(0, 2'b01, 8'h00, 1'b1, 8'h22);
        ex(1, 2'b01, 8'h00, 1'b1, 8'h33);
        ex(2, 2'b01, 8'h00, 1'b1, 8'h44);
        ex(3, 2'b01, 8'h00, 1'b1, 8'h55);
        check_log("left_flush", 4);
        chk("left_flush_busy", BUSY, 1'b0);

        // Direction change forces a left drain before the right word
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        push(8'h44, 1'b0);
        push(8'hA0, 1'b1);
        tick(14);
        ex(0, 2'b01, 8'h11, 1'b0, 8'h00);
        ex(1, 2'b01, 8'h22, 1'b0, 8'h00);
        ex(2, 2'b01, 8'h33, 1'b0, 8'h00);
        ex(3, 2'b01, 8'h44, 1'b0, 8'h00);
        ex(4, 2'b01, 8'h00, 1'b1, 8'h11);
        ex(5, 2'b01, 8'h00, 1'b1, 8'h22);
        ex(6, 2'b01, 8'h00, 1'b1, 8'h33);
        ex(7, 2'b01, 8'h00, 1'b1, 8'h44);
        ex(8, 2'b10, 8'hA0, 1'b0, 8'h00);
        check_log("dirchg", 9);
        pulse_flush();
        tick(8);
        ex(0, 2'b10, 8'h00, 1'b0, 8'h00);
        ex(1, 2'b10, 8'h00, 1'b0, 8'h00);
        ex(2, 2'b10, 8'h00, 1'b0, 8'h00);
        ex(3, 2'b10, 8'h00, 1'b1, 8'hA0);
        check_log("right_flush", 4);
        chk("right_flush_busy", BUSY, 1'b0);

        // Flush of a partly filled register
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        pulse_flush();
        tick(10);
        ex(0, 2'b01, 8'h01, 1'b0, 8'h00);
        ex(1, 2'b01, 8'h02, 1'b0, 8'h00);
        ex(2, 2'b01, 8'h00, 1'b0, 8'h00);
        ex(3, 2'b01, 8'h00, 1'b0, 8'h00);
        ex(4, 2'b01, 8'h00, 1'b1, 8'h01);
        ex(5, 2'b01, 8'h00, 1'b1, 8'h02);
        check_log("flush", 6);
        chk("flush_busy", BUSY, 1'b0);

        // Backpressure: fill FIFO under HOLD, then release
        HOLD = 1'b1;
        push(8'hC1, 1'b0);
        push(8'hC2, 1'b0);
        push(8'hC3, 1'b0);
        push(8'hC4, 1'b0);
        S_VALID = 1'b1;
        S_DATA  = 8'hC5;
        S_DIR   = 1'b0;
        @(negedge CLK);
        chk("bp_full_s_ready", S_READY, 1'b0);
        chk("bp_hold_shift", SHIFT, 2'b00);
        tick(1);
        @(negedge CLK);
        chk("bp_full_s_ready2", S_READY, 1'b0);
        @(posedge CLK);
        #1;
        HOLD = 1'b0;
        @(negedge CLK);
        chk("bp_release_s_ready", S_READY, 1'b0);
        chk("bp_release_shift", SHIFT, 2'b00);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("bp_pop_shift", SHIFT, 2'b01);
        chk("bp_pop_s_ready", S_READY, 1'b0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("bp_after_pop_s_ready", S_READY, 1'b1);
        @(posedge CLK);
        #1;
        S_DATA = 8'hC6;
        @(negedge CLK);
        chk("bp_c6_s_ready", S_READY, 1'b1);
        @(posedge CLK);
        #1;
        S_VALID = 1'b0;
        tick(10);
        ex(0, 2'b01, 8'hC1, 1'b0, 8'h00);
        ex(1, 2'b01, 8'hC2, 1'b0, 8'h00);
        ex(2, 2'b01, 8'hC3, 1'b0, 8'h00);
        ex(3, 2'b01, 8'hC4, 1'b0, 8'h00);
        ex(4, 2'b01, 8'hC5, 1'b1, 8'hC1);
        ex(5, 2'b01, 8'hC6, 1'b1, 8'hC2);
        check_log("bp", 6);
        pulse_flush();
        tick(8);
        ex(0, 2'b01, 8'h00, 1'b1, 8'hC3);
        ex(1, 2'b01, 8'h00, 1'b1, 8'hC4);
        ex(2, 2'b01, 8'h00, 1'b1, 8'hC5);
        ex(3, 2'b01, 8'h00, 1'b1, 8'hC6);
        check_log("bp_flush", 4);

        // Twelve sparse pushes wrap the FIFO pointers three times
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("wrap_s_ready[%0d]", k), S_READY, 1'b1);
            push(8'hB0 + 8'(k), 1'b0);
            tick(2);
        end
        tick(4);
        for (int k = 0; k < 12; k++) begin
            ex(k, 2'b01, 8'hB0 + 8'(k), (k >= 4),
               (k >= 4) ? 8'hB0 + 8'(k - 4) : 8'h00);
        end
        check_log("wrap", 12);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/siso_shift_sequencer_nb.md
# siso_shift_sequencer_Nb

Upstream feeder for the N-bit SISO left/right shift register. It buffers direction-tagged words from a valid/ready source in a small FIFO and drives the shift register's SHIFT and IN pins one word per cycle. When the direction changes or a flush is requested, it inserts drain shifts so that every loaded word leaves the register. It mirrors register occupancy in a valid-bit vector and raises OUT_VALID on exactly the cycles when the shift register's OUT carries a real word.

## Interface
- BUS_WIDTH, 8, word width; must match the shift register
- SISO_WIDTH, 4, shift register depth in words; ≥2
- FIFO_DEPTH, 4, input buffer depth in words; power of two, ≥2
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- S_VALID  in  1  source word valid
- S_READY  out  1  sequencer can accept a word
- S_DATA  in  BUS_WIDTH  source word
- S_DIR  in  1  0 = left shift (SHIFT=01), 1 = right shift (SHIFT=10)
- FLUSH  in  1  single-cycle request to drain the register once the FIFO is empty
- HOLD  in  1  downstream stall; freezes sequencing
- SHIFT  out  2  to shift register SHIFT
- SH_IN  out  BUS_WIDTH  to shift register IN
- OUT_VALID  out  1  shift register OUT holds a real word this cycle
- BUSY  out  1  state ≠ IDLE, FIFO non-empty, or any valid bit set

## Operation
- FIFO: stores {dir, data}; registered read/write pointers of log2(FIFO_DEPTH) bits plus a wrap bit. Push when S_VALID && S_READY. S_READY = !full and is derived from registered state only; a pop in the same cycle does not raise it.
- Registers: state, cur_dir, vbits[SISO_WIDTH-1:0], flush_pend.
- vbits mirror the shift register. Left shift: vbits <= {vbits[SISO_WIDTH-2:0], in_valid}. Right shift: vbits <= {in_valid, vbits[SISO_WIDTH-1:1]}. in_valid = 1 for a popped word, 0 for a drain shift.
- OUT_VALID = shift cycle && exiting bit set. The exiting bit is vbits[SISO_WIDTH-1] for a left shift and vbits[0] for a right shift.
- flush_pend: set by FLUSH; cleared when DRAIN completes or when it is set while vbits==0 and the FIFO is empty.
- States:
  - IDLE:
    - SHIFT=00.
    - If the FIFO is non-empty and (head dir == cur_dir or vbits==0): load cur_dir from head, go to SHIFT_ST.
    - If the FIFO is non-empty and head dir ≠ cur_dir with vbits≠0: go to DRAIN.
    - If the FIFO is empty, flush_pend is set and vbits≠0: go to DRAIN.
  - SHIFT_ST:
    - If the head dir matches cur_dir: pop the head, SHIFT = cur_dir ? 10 : 01, SH_IN = head data.
    - If the FIFO is empty: SHIFT=00, go to IDLE.
    - If the head dir differs: SHIFT=00, go to DRAIN if vbits≠0, otherwise to IDLE.
  - DRAIN:
    - SHIFT per cur_dir, SH_IN = 0, no pop.
    - When the next vbits == 0, clear flush_pend and go to IDLE.
- HOLD=1: SHIFT=00, SH_IN=0, OUT_VALID=0. No pop, no vbits/state/cur_dir change. FIFO pushes are still accepted.
- SHIFT, SH_IN and OUT_VALID are combinational from registered state and the FIFO head. The shift register and this block sample on the same edge.

## Timing
- Reset values: SHIFT=00, SH_IN=0, OUT_VALID=0, BUSY=0, S_READY=1, state=IDLE, cur_dir=0, vbits=0, flush_pend=0, FIFO empty.
- RST mid-operation discards FIFO contents and vbits immediately. Any stale shift-register contents are never flagged valid.
- Latency, accept to drive: a word accepted at edge N is driven on SHIFT/SH_IN in cycle N+2. IDLE to SHIFT_ST takes one cycle.
- Steady state: one word per cycle in SHIFT_ST. A word pushed at position k exits with OUT_VALID on the SISO_WIDTH-th subsequent shift in the same direction.
- Direction change drain: at most SISO_WIDTH cycles, ending when the last valid bit has exited.
- FLUSH during SHIFT_ST is latched and acted on once the FIFO empties.
- FIFO pointers wrap modulo FIFO_DEPTH. Full is signalled when the pointers are equal with different wrap bits.

## Test plan
- Reset: assert RST mid-stream with 3 words buffered → SHIFT=00, OUT_VALID=0, BUSY=0, S_READY=1 while RST is high and on the first cycle after release.
- Left stream: push 0x11,0x22,0x33,0x44,0x55, all S_DIR=0, back-to-back → five consecutive SHIFT=01 cycles. OUT_VALID=1 only on the fifth cycle, where the register OUT = 0x11.
- Direction change: push 0x11..0x44 left, then 0xA0 right → after four left shifts, four drain cycles (SHIFT=01, SH_IN=00) with OUT_VALID=1 and OUT 0x11,0x22,0x33,0x44. Then SHIFT=10 with SH_IN=0xA0.
- Flush: push 0x01,0x02 left, then pulse FLUSH → four drain cycles. OUT_VALID=1 on drain cycles 3 and 4 with OUT 0x01 and 0x02, then BUSY=0.
- Backpressure: hold HOLD=1 and push 6 words → S_READY falls after the 4th accept, SHIFT stays 00. Release HOLD → words drain in order and S_READY rises one cycle after the first pop.
- FIFO wrap: 12 single-word pushes with idle gaps → data order preserved across 3 pointer wraps and no spurious S_READY=0.
